// File: rtl/temporal_bundler_hf_if.sv
// Sample-in / query-out bundle for temporal_bundler_hf.
// The block is the slave. A master drives the samples and observes the query.
interface temporal_bundler_hf_if #(
  parameter int DIMENSIONS = 5,
  parameter int WINDOW     = 3
);
  localparam int CNT_W = $clog2(WINDOW + 1);

  logic                  in_valid;
  logic [DIMENSIONS-1:0] in_hv;
  logic                  clear;
  logic                  out_en;
  logic [DIMENSIONS-1:0] out_hv;
  logic [CNT_W-1:0]      fill;

  modport master (output in_valid, in_hv, clear, input  out_en, out_hv, fill);
  modport slave  (input  in_valid, in_hv, clear, output out_en, out_hv, fill);
endinterface

// File: rtl/temporal_bundler_hf.sv
// Majority-bundles WINDOW consecutive encoded samples into one query hypervector.
// The query is presented with a single-cycle out_en pulse.
module temporal_bundler_hf #(
  parameter int DIMENSIONS = 5,
  parameter int WINDOW     = 3
) (
  input  logic                 clk,
  input  logic                 nrst,
  temporal_bundler_hf_if.slave bus
);
  localparam int              CNT_W = $clog2(WINDOW + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  logic [DIMENSIONS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]                 scnt_q, scnt_d;
  logic [DIMENSIONS-1:0]            hv_q, hv_d, maj;
  logic                             en_q, en_d;
  logic                             accept, done;

  assign accept = bus.in_valid & ~bus.clear;
  assign done   = accept && (scnt_q == LAST);

  // The completing sample is folded into the vote. Ties (2*count == WINDOW) resolve to 0.
  for (genvar g = 0; g < DIMENSIONS; g++) begin : g_lane
    logic [CNT_W+1:0] sum2;
    assign sum2   = {1'b0, cnt_q[g] + CNT_W'(bus.in_hv[g]), 1'b0};
    assign maj[g] = sum2 > (CNT_W+2)'(WINDOW);
  end

  always_comb begin
    cnt_d  = cnt_q;
    scnt_d = scnt_q;
    hv_d   = hv_q;
    en_d   = 1'b0;
    if (bus.clear) begin
      cnt_d  = '0;
      scnt_d = '0;
    end else if (done) begin
      cnt_d  = '0;
      scnt_d = '0;
      hv_d   = maj;
      en_d   = 1'b1;
    end else if (accept) begin
      for (int i = 0; i < DIMENSIONS; i++)
        cnt_d[i] = cnt_q[i] + CNT_W'(bus.in_hv[i]);
      scnt_d = scnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt_q  <= '0;
      scnt_q <= '0;
      hv_q   <= '0;
      en_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      scnt_q <= scnt_d;
      hv_q   <= hv_d;
      en_q   <= en_d;
    end
  end

  assign bus.out_en = en_q;
  assign bus.out_hv = hv_q;
  assign bus.fill   = scnt_q;
endmodule

// File: doc/temporal_bundler_hf.md
Name: temporal_bundler_hf

Overview:
- Upstream stage of similarity_hf in the HDC seizure-detection datapath.
- Receives one spatially encoded hypervector per sample period and majority-bundles WINDOW consecutive samples into a single query hypervector.
- Emits that query on out_hv with a one-cycle out_en pulse, which drives similarity_hf's hv and en directly.

Parameters:
- DIMENSIONS, 5: hypervector width in bits. The default suits simulation; the deployed value is set at the top level.
- WINDOW, 3: number of samples bundled per query. Legal range 1..255.
- CNT_W, $clog2(WINDOW+1): width of the per-dimension and sample counters. Derived; must not be overridden.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- nrst  input  1  asynchronous active-low reset.
- in_valid  input  1  in_hv is valid this cycle and is accepted; there is no backpressure.
- in_hv  input  DIMENSIONS  encoded sample hypervector.
- clear  input  1  synchronous flush of the partial window.
- out_en  output  1  one-cycle pulse when out_hv has just been updated.
- out_hv  output  DIMENSIONS  bundled query hypervector; holds its value between pulses.
- fill  output  CNT_W  number of samples accepted into the current window, 0..WINDOW-1.

Behaviour:
- Reset (nrst=0, asynchronous):
  - all per-dimension counters = 0, sample counter = 0
  - out_hv = 0, out_en = 0, fill = 0
  - The block is usable on the first rising edge after nrst deasserts.
- State: DIMENSIONS counters cnt[i] of CNT_W bits each, plus a sample counter scnt of CNT_W bits. fill = scnt.
- Accept rule: on a rising edge with in_valid=1 and clear=0:
  - cnt[i] += in_hv[i] for every i.
  - If scnt < WINDOW-1: scnt += 1.
- Window completion: an accepted sample while scnt == WINDOW-1 completes the window. On that same edge:
  - out_hv[i] <= 1 if 2*(cnt[i] + in_hv[i]) > WINDOW, else 0. The completing sample counts toward the result.
  - Ties (possible only for even WINDOW, 2*count == WINDOW) resolve to 0.
  - out_en <= 1.
  - All cnt[i] <= 0 and scnt <= 0.
- Latency: out_en and the new out_hv are visible in the cycle after the edge that captured the last sample of the window.
- out_en:
  - High for exactly one cycle per completed window, otherwise 0.
  - Never high on two consecutive cycles unless WINDOW=1 and in_valid is held high.
- out_hv changes only on window completion or reset.
- Back-to-back input: in_valid=1 in the cycle where out_en=1 is accepted as sample 0 of the next window. No samples are lost and no stall occurs.
- WINDOW=1: every accepted sample completes a window, so out_hv <= in_hv and out_en pulses the next cycle.
- Counter width: cnt[i] cannot exceed WINDOW-1 before completion, so CNT_W cannot overflow. scnt wraps only through the completion path.
- clear=1 on an edge:
  - all cnt[i] <= 0, scnt <= 0, out_en <= 0
  - out_hv holds its value.
  - clear takes priority over in_valid: a simultaneous sample is dropped.
  - clear on the would-be completing edge suppresses that output. No pulse, out_hv unchanged.
- Reset mid-window discards the partial window. A reset coincident with an out_en pulse drops the pulse immediately, since the reset is asynchronous.
- in_valid=0 cycles between samples are allowed and have no effect. Gaps of any length inside a window are legal.
- in_hv is ignored when in_valid=0.

Test Plan:
- WINDOW=3, reset held 95 ns then released; accept 00101, 00111, 11011 on three non-consecutive valid cycles -> out_en pulses once the cycle after the third sample, out_hv=00111, fill sequence 1,2,0.
- WINDOW=3, six back-to-back valid cycles with 00101,00111,11011,11111,11111,00000 -> out_en pulses twice, three cycles apart; out_hv=00111 then 11111; no sample lost.
- WINDOW=4 tie: accept 00011,00001,00010,00000 -> out_hv=00000 (bit0 and bit1 tie at 2/4 and resolve to 0). Repeat with 00011,00011,00001,00000 -> out_hv=00001.
- clear: WINDOW=3, accept 11111,11111, then clear together with in_valid=1 carrying 11111 -> no out_en, fill=0, out_hv unchanged. Next 00001 x3 -> out_hv=00001.
- Async reset mid-window: WINDOW=3, accept two samples, pulse nrst low between clock edges -> fill, out_hv and out_en drop to 0 immediately. A following full window produces the correct bundled result.
- WINDOW=1 pass-through: in_valid held high with 00001,00101,11011,11111 -> out_en high for four consecutive cycles; out_hv tracks the inputs with 1-cycle latency.
